// File: rtl/mst_fifo_burst_ctrl.sv
// rtl/mst_fifo_burst_ctrl.sv - FT600/FT601 master bus controller with bounded bursts and write residue replay
module mst_fifo_burst_ctrl #(
  parameter int DW        = 16,
  parameter int BEW       = DW / 8,
  parameter int MAX_BURST = 256,
  parameter int ARB_MODE  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           txe_n,
  input  logic           rxf_n,
  input  logic [DW-1:0]  idata,
  input  logic [BEW-1:0] ibe,
  output logic [DW-1:0]  odata,
  output logic [BEW-1:0] obe,
  output logic           dt_oe_n,
  output logic           be_oe_n,
  output logic           wr_n,
  output logic           rd_n,
  output logic           oe_n,
  output logic [DW-1:0]  rx_data,
  output logic [BEW-1:0] rx_be,
  output logic           rx_valid,
  input  logic           rx_ready,
  input  logic [DW-1:0]  tx_data,
  input  logic [BEW-1:0] tx_be,
  input  logic           tx_valid,
  output logic           tx_ready,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_OE,
    S_RD,
    S_WR,
    S_TURN
  } state_t;

  localparam logic [15:0] MAX_B = 16'(MAX_BURST);

  state_t      state;
  logic        hold_vld;   // odata/obe carry a beat not yet taken by the chip
  logic [15:0] beat_cnt;
  logic        rr_last;    // 1 = the last granted burst was a write

  logic        rd_req;
  logic        wr_req;
  logic        pick_rd;
  logic        cnt_below;
  logic        wr_accept;
  logic        rd_capture;
  logic        tx_take;
  logic        hold_next;
  logic [15:0] cnt_next;
  logic        cnt_full_next;
  logic        rd_go;
  logic        wr_go;

  assign rd_req     = !rxf_n && rx_ready;
  assign wr_req     = !txe_n && (tx_valid || hold_vld);
  assign cnt_below  = (beat_cnt < MAX_B);
  // The chip takes the presented beat only when it still has room at the edge.
  assign wr_accept  = (state == S_WR) && !wr_n && !txe_n;
  assign rd_capture = (state == S_RD) && !rd_n && !rxf_n;
  // The hold register may be refilled in the same cycle the chip drains it.
  assign tx_ready   = (state == S_WR) && (!hold_vld || wr_accept) && cnt_below;
  assign tx_take    = tx_valid && tx_ready;
  assign hold_next  = tx_take || (hold_vld && !wr_accept);
  assign cnt_next   = ((wr_accept || rd_capture) && cnt_below) ? beat_cnt + 16'd1 : beat_cnt;
  assign cnt_full_next = (cnt_next >= MAX_B);
  // A burst continues only while the next strobe could still move a beat.
  assign rd_go      = !rxf_n && rx_ready && !cnt_full_next;
  assign wr_go      = hold_next && !txe_n && !cnt_full_next;
  assign busy       = (state != S_IDLE);

  // Arbitrate between pending read and write when both are requested in IDLE.
  always_comb begin
    pick_rd = 1'b0;
    if (rd_req && !wr_req) begin
      pick_rd = 1'b1;
    end else if (rd_req && wr_req) begin
      if (ARB_MODE == 0) begin
        pick_rd = 1'b1;
      end else if (ARB_MODE == 1) begin
        pick_rd = 1'b0;
      end else begin
        pick_rd = rr_last;
      end
    end
  end

  // Bus FSM with registered strobes, output enables, hold register and rx capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
      oe_n     <= 1'b1;
      dt_oe_n  <= 1'b1;
      be_oe_n  <= 1'b1;
      odata    <= '1;
      obe      <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_be    <= '0;
      hold_vld <= 1'b0;
      beat_cnt <= 16'd0;
      rr_last  <= 1'b1;
    end else begin
      rx_valid <= rd_capture;
      if (rd_capture) begin
        rx_data <= idata;
        rx_be   <= ibe;
      end
      case (state)
        S_IDLE: begin
          beat_cnt <= 16'd0;
          if (pick_rd) begin
            state   <= S_RD_OE;
            oe_n    <= 1'b0;
            rr_last <= 1'b0;
          end else if (wr_req) begin
            state   <= S_WR;
            dt_oe_n <= 1'b0;
            be_oe_n <= 1'b0;
            rr_last <= 1'b1;
          end
        end
        S_RD_OE: begin
          state <= S_RD;
          rd_n  <= !rd_go;
        end
        S_RD: begin
          beat_cnt <= cnt_next;
          if (rd_go) begin
            rd_n <= 1'b0;
          end else begin
            rd_n  <= 1'b1;
            oe_n  <= 1'b1;
            state <= S_TURN;
          end
        end
        S_WR: begin
          beat_cnt <= cnt_next;
          hold_vld <= hold_next;
          if (tx_take) begin
            odata <= tx_data;
            obe   <= tx_be;
          end else if (wr_accept) begin
            odata <= '1;
            obe   <= '1;
          end
          if (wr_go) begin
            wr_n <= 1'b0;
          end else begin
            wr_n    <= 1'b1;
            dt_oe_n <= 1'b1;
            be_oe_n <= 1'b1;
            state   <= S_TURN;
          end
        end
        S_TURN: begin
          wr_n     <= 1'b1;
          rd_n     <= 1'b1;
          oe_n     <= 1'b1;
          dt_oe_n  <= 1'b1;
          be_oe_n  <= 1'b1;
          beat_cnt <= 16'd0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mst_fifo_burst_ctrl.sv
// tb/tb_mst_fifo_burst_ctrl.sv - scoreboard bench for mst_fifo_burst_ctrl with an FT60x chip model
module tb_mst_fifo_burst_ctrl;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int MB  = 4;

  typedef logic [35:0] beat_t;

  logic           clk;
  logic           rst;
  logic           txe_n;
  logic           rxf_n;
  logic [DW-1:0]  idata;
  logic [BEW-1:0] ibe;
  logic [DW-1:0]  odata;
  logic [BEW-1:0] obe;
  logic           dt_oe_n;
  logic           be_oe_n;
  logic           wr_n;
  logic           rd_n;
  logic           oe_n;
  logic [DW-1:0]  rx_data;
  logic [BEW-1:0] rx_be;
  logic           rx_valid;
  logic           rx_ready;
  logic [DW-1:0]  tx_data;
  logic [BEW-1:0] tx_be;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;

  mst_fifo_burst_ctrl #(.DW(DW), .BEW(BEW), .MAX_BURST(MB), .ARB_MODE(2)) dut (
    .clk(clk), .rst(rst), .txe_n(txe_n), .rxf_n(rxf_n), .idata(idata), .ibe(ibe),
    .odata(odata), .obe(obe), .dt_oe_n(dt_oe_n), .be_oe_n(be_oe_n),
    .wr_n(wr_n), .rd_n(rd_n), .oe_n(oe_n),
    .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_be(tx_be), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  beat_t chip_rx_q[$];
  beat_t exp_rx_q[$];
  beat_t tx_src_q[$];
  beat_t exp_wr_q[$];
  beat_t obs_wr_q[$];
  int    cap_q[$];
  int    burst_len_q[$];
  int    burst_kind_q[$];
  int    exp_len_q[$];
  int    exp_kind_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_total = 0;
  int wr_accepts = 0;
  int txe_block = 0;
  bit rx_rand = 0;
  bit txe_rand = 0;
  bit txe_force = 1;
  bit t3_arm = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b = {4'($urandom), 32'($urandom)};
    return b;
  endfunction

  // FT60x chip model and user tx source: drive at negedge, predict edge events just before posedge
  initial begin
    beat_t dummy;
    txe_n = 1'b1; rxf_n = 1'b1; idata = '0; ibe = '0;
    tx_valid = 1'b0; tx_data = '0; tx_be = '0;
    forever begin
      @(negedge clk);
      if (chip_rx_q.size() > 0) begin
        idata = chip_rx_q[0][31:0];
        ibe   = chip_rx_q[0][35:32];
        rxf_n = rx_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end else begin
        idata = 32'($urandom);
        ibe   = 4'($urandom);
        rxf_n = 1'b1;
      end
      if (t3_arm && wr_accepts == 2) begin
        txe_block = 3;
        t3_arm = 1'b0;
      end
      txe_n = txe_force || (txe_block > 0) || (txe_rand && ($urandom_range(0, 3) == 0));
      if (txe_block > 0) txe_block--;
      if (tx_src_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = tx_src_q[0][31:0];
        tx_be    = tx_src_q[0][35:32];
      end else begin
        tx_valid = 1'b0;
        tx_data  = 32'($urandom);
        tx_be    = 4'($urandom);
      end
      #1;
      if (!rst && !rd_n && !rxf_n) begin
        dummy = chip_rx_q.pop_front();
        cap_q.push_back(cyc + 1);
      end
      if (!rst && !wr_n && !txe_n) begin
        obs_wr_q.push_back({obe, odata});
        wr_accepts++;
      end
      if (!rst && tx_valid && tx_ready) dummy = tx_src_q.pop_front();
    end
  end

  // Monitor: scoreboards, bus invariants and burst bookkeeping, sampled 1 time unit after posedge
  initial begin
    beat_t e;
    beat_t o;
    bit    exp_v;
    bit    in_burst;
    int    cur_len;
    int    kind;
    in_burst = 0; cur_len = 0; kind = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_burst = 0; cur_len = 0; kind = 0;
        cap_q.delete();
        obs_wr_q.delete();
      end else begin
        check("strobe_exclusive", 64'(rd_n | wr_n), 64'(1));
        check("bus_exclusive", 64'(dt_oe_n | oe_n), 64'(1));
        if (cap_q.size() > 0 && cap_q[0] < cyc) begin
          check("rx_capture_lost", 64'(0), 64'(1));
          void'(cap_q.pop_front());
        end
        exp_v = (cap_q.size() > 0) && (cap_q[0] == cyc);
        if (rx_valid || exp_v) check("rx_latency", 64'(rx_valid), 64'(exp_v));
        if (exp_v) void'(cap_q.pop_front());
        if (rx_valid) begin
          rx_total++;
          cur_len++;
          if (exp_rx_q.size() == 0) begin
            check("rx_unexpected", 64'(1), 64'(0));
          end else begin
            e = exp_rx_q.pop_front();
            check("rx_beat", 64'({rx_be, rx_data}), 64'(e));
          end
        end
        while (obs_wr_q.size() > 0) begin
          o = obs_wr_q.pop_front();
          cur_len++;
          if (exp_wr_q.size() == 0) begin
            check("wr_unexpected", 64'(1), 64'(0));
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_beat", 64'(o), 64'(e));
          end
        end
        if (busy) begin
          in_burst = 1;
          if (!oe_n) kind = kind | 1;
          if (!dt_oe_n) kind = kind | 2;
        end else if (in_burst) begin
          check("burst_len_max", 64'(cur_len <= MB), 64'(1));
          burst_len_q.push_back(cur_len);
          burst_kind_q.push_back(kind);
          in_burst = 0; cur_len = 0; kind = 0;
        end
      end
    end
  end

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(chip_rx_q.size() == 0 && tx_src_q.size() == 0 && exp_rx_q.size() == 0 &&
                 exp_wr_q.size() == 0 && !busy) && n < budget);
    check(nm, 64'(n < budget), 64'(1));
  endtask

  task automatic compare_bursts(input string nm);
    check({nm, "_count"}, 64'(burst_len_q.size()), 64'(exp_len_q.size()));
    for (int i = 0; i < exp_len_q.size() && i < burst_len_q.size(); i++) begin
      check({nm, "_len"}, 64'(burst_len_q[i]), 64'(exp_len_q[i]));
      check({nm, "_kind"}, 64'(burst_kind_q[i]), 64'(exp_kind_q[i]));
    end
    burst_len_q.delete(); burst_kind_q.delete();
    exp_len_q.delete(); exp_kind_q.delete();
  endtask

  task automatic push_rx(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = rand_beat();
      chip_rx_q.push_back(b);
      exp_rx_q.push_back(b);
    end
  endtask

  task automatic push_tx(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = rand_beat();
      tx_src_q.push_back(b);
      exp_wr_q.push_back(b);
    end
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_wr_n", 64'(wr_n), 64'(1));
    check("rst_rd_n", 64'(rd_n), 64'(1));
    check("rst_oe_n", 64'(oe_n), 64'(1));
    check("rst_dt_oe_n", 64'(dt_oe_n), 64'(1));
    check("rst_be_oe_n", 64'(be_oe_n), 64'(1));
    check("rst_odata", 64'(odata), 64'(32'hFFFF_FFFF));
    check("rst_obe", 64'(obe), 64'(4'hF));
    check("rst_rx_valid", 64'(rx_valid), 64'(0));
    check("rst_rx_data", 64'({rx_be, rx_data}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // T1: 8 received beats, split into two maximal read bursts
    burst_len_q.delete(); burst_kind_q.delete();
    base = rx_total;
    push_rx(8);
    wait_drain("t1_drain", 400);
    check("t1_rx_count", 64'(rx_total - base), 64'(8));
    exp_len_q = '{4, 4}; exp_kind_q = '{1, 1};
    compare_bursts("t1_bursts");

    // T2: 10 tx beats held valid -> bursts 4, 4, 2
    txe_force = 1'b0;
    push_tx(10);
    wait_drain("t2_drain", 400);
    exp_len_q = '{4, 4, 2}; exp_kind_q = '{2, 2, 2};
    compare_bursts("t2_bursts");

    // T3: txe_n rises while beat 3 is presented; it is replayed first
    wr_accepts = 0;
    t3_arm = 1'b1;
    push_tx(6);
    wait_drain("t3_drain", 400);
    check("t3_triggered", 64'(t3_arm), 64'(0));
    check("t3_accepts", 64'(wr_accepts), 64'(6));
    exp_len_q = '{2, 4}; exp_kind_q = '{2, 2};
    compare_bursts("t3_bursts");

    // T4: contention under round-robin alternates starting with read (last grant was write)
    push_rx(8);
    push_tx(8);
    wait_drain("t4_drain", 600);
    exp_len_q = '{4, 4, 4, 4}; exp_kind_q = '{1, 2, 1, 2};
    compare_bursts("t4_bursts");

    // T5: rx_ready drops mid-read
    txe_force = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    base = rx_total;
    push_rx(4);
    n = 0;
    while (rx_total == base && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t5_first_rx_seen", 64'(n < 50), 64'(1));
    rx_ready = 1'b0;
    base = rx_total;
    @(posedge clk);
    #2;
    check("t5_rd_n_high", 64'(rd_n), 64'(1));
    repeat (6) @(posedge clk);
    #2;
    check("t5_extra_rx_le2", 64'(rx_total - base <= 2), 64'(1));
    check("t5_idle", 64'(busy), 64'(0));
    check("t5_words_left", 64'(chip_rx_q.size() > 0), 64'(1));
    rx_ready = 1'b1;
    wait_drain("t5_drain", 400);
    burst_len_q.delete(); burst_kind_q.delete();

    // T6: reset while in WR with a beat in the hold register
    txe_force = 1'b0;
    push_tx(3);
    n = 0;
    while (!(dt_oe_n == 1'b0 && wr_n == 1'b0) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t6_wr_reached", 64'(n < 50), 64'(1));
    txe_force = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("t6_wr_n", 64'(wr_n), 64'(1));
    check("t6_rd_n", 64'(rd_n), 64'(1));
    check("t6_oe_n", 64'(oe_n), 64'(1));
    check("t6_dt_oe_n", 64'(dt_oe_n), 64'(1));
    check("t6_odata", 64'(odata), 64'(32'hFFFF_FFFF));
    check("t6_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    tx_src_q.delete();
    exp_wr_q.delete();
    obs_wr_q.delete();
    txe_force = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("t6_hold_dropped_idle", 64'(busy), 64'(0));
    check("t6_hold_dropped_odata", 64'(odata), 64'(32'hFFFF_FFFF));
    burst_len_q.delete(); burst_kind_q.delete();

    // Randomized traffic with random chip flags and downstream readiness
    rx_rand = 1'b1;
    txe_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2;
      rx_ready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 4) == 0) push_rx(1);
      if ($urandom_range(0, 4) == 0) push_tx(1);
    end
    rx_rand = 1'b0;
    txe_rand = 1'b0;
    rx_ready = 1'b1;
    wait_drain("rand_drain", 3000);
    repeat (3) @(posedge clk);
    #2;
    check("end_rx_empty", 64'(exp_rx_q.size()), 64'(0));
    check("end_wr_empty", 64'(exp_wr_q.size()), 64'(0));
    check("end_obs_empty", 64'(obs_wr_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
